// File: rtl/zpu_alu_arb_pkg.sv
// Shared types and constants for the ZPU ALU arbiter (state enum, requester id, counter width).
`include "zpu_defines.sv"

package zpu_alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RESP    = 2'd2,
    ST_RECOVER = 2'd3
  } arb_state_e;

  typedef logic req_id_t;

  // Wide enough for TIMEOUT_CYC up to 255.
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NOP_W  = `ALU_OP_WIDTH;
  localparam logic [NOP_W-1:0] OP_NOP = `ALU_NOP;

endpackage

// File: rtl/zpu_defines.sv
// ZPU ALU opcode definitions shared by the ALU, its arbiter and anything that drives them.
`ifndef ZPU_DEFINES_SV
`define ZPU_DEFINES_SV

`define ALU_OP_WIDTH 4
`define ALU_NOP      4'h0
`define ALU_PLUS     4'h1
`define ALU_AND      4'h2
`define ALU_OR       4'h3
`define ALU_XOR      4'h4
`define ALU_SUB      4'h5

`endif

// File: rtl/zpu_rr_arbiter.sv
// Two-way grant logic. Round-robin when ALU_ARB_RR_EN is defined, else fixed priority to requester 0.
module zpu_rr_arbiter (
`ifdef ALU_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       accept_i,
`endif
  input  logic [1:0] valid_i,
  output logic [1:0] grant_c_o
);

`ifdef ALU_ARB_RR_EN
  // prio_q names the requester that wins a tie; it flips to the loser on each handshake.
  logic prio_q;
  logic prio_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

  always_comb begin
    grant_c_o = valid_i;
    if (valid_i == 2'b11) grant_c_o = prio_q ? 2'b10 : 2'b01;
    prio_d = prio_q;
    if (accept_i) prio_d = grant_c_o[0];
  end
`else
  always_comb begin
    grant_c_o = {valid_i[1] & ~valid_i[0], valid_i[0]};
  end
`endif

endmodule

// File: rtl/zpu_alu_arb.sv
// Shares one ZPU ALU between two requesters: IDLE -> RUN -> RESP -> RECOVER.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
`include "zpu_defines.sv"

module zpu_alu_arb
  import zpu_alu_arb_pkg::*;
#(
  parameter int unsigned OP_W        = `ALU_OP_WIDTH,
  parameter int unsigned TIMEOUT_CYC = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_idim,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_idim,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_r,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_r,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              flag_idim,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_done
);

  arb_state_e              state_q, state_d;
  req_id_t                 id_q, id_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OP_W-1:0]         op_q, op_d;
  logic [DATA_W-1:0]       a_q, a_d, b_q, b_d;
  logic                    idim_q, idim_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic [1:0]              rsp_err_q, rsp_err_d;
  logic [1:0][DATA_W-1:0]  rsp_r_q, rsp_r_d;
  logic [1:0]              grant_c, ready_c;
  logic                    hs_c;

  // Ready only in IDLE and never while reset is held.
  assign ready_c = grant_c & {2{(state_q == ST_IDLE) && !reset}};
  assign hs_c    = |(ready_c & {req1_valid, req0_valid});

  zpu_rr_arbiter u_arb (
`ifdef ALU_ARB_RR_EN
    .clk       (clk),
    .rst       (reset),
    .accept_i  (hs_c),
`endif
    .valid_i   ({req1_valid, req0_valid}),
    .grant_c_o (grant_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      op_q        <= OP_W'(OP_NOP);
      a_q         <= '0;
      b_q         <= '0;
      idim_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_r_q     <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idim_q      <= idim_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_r_q     <= rsp_r_d;
    end
  end

  // ALU drive defaults to NOP/zero; only a RUN state holds the captured payload.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    op_d        = OP_W'(OP_NOP);
    a_d         = '0;
    b_d         = '0;
    idim_d      = 1'b0;
    rsp_valid_d = '0;
    rsp_err_d   = '0;
    rsp_r_d     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (hs_c) begin
          state_d = ST_RUN;
          id_d    = ready_c[1];
          cnt_d   = CNT_W'(1);
          op_d    = ready_c[1] ? req1_op   : req0_op;
          a_d     = ready_c[1] ? req1_a    : req0_a;
          b_d     = ready_c[1] ? req1_b    : req0_b;
          idim_d  = ready_c[1] ? req1_idim : req0_idim;
        end
      end
      ST_RUN: begin
        if (alu_done) begin
          state_d              = ST_RESP;
          cnt_d                = '0;
          rsp_valid_d[id_q]    = 1'b1;
          rsp_r_d[id_q]        = alu_r;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          state_d              = ST_RESP;
          cnt_d                = '0;
          rsp_valid_d[id_q]    = 1'b1;
          rsp_err_d[id_q]      = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          op_d   = op_q;
          a_d    = a_q;
          b_d    = b_q;
          idim_d = idim_q;
        end
      end
      ST_RESP:    state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign req0_ready = ready_c[0];
  assign req1_ready = ready_c[1];
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_r     = rsp_r_q[0];
  assign rsp1_r     = rsp_r_q[1];
  assign rsp0_err   = rsp_err_q[0];
  assign rsp1_err   = rsp_err_q[1];
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign flag_idim  = idim_q;

endmodule

// File: doc/zpu_alu_arb.md
ZPU_ALU_ARB -- requirements
Module: zpu_alu_arb

Interface
REQ-001 SHALL have parameter OP_W, default `ALU_OP_WIDTH, ALU opcode width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 63, maximum RUN cycles allowed without alu_done (range 1..255).
REQ-003 SHALL have one clock and an asynchronous, active-high reset, as the following port lines state.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 reqN_valid  in  1  requester N (N=0,1) has an operation pending.
REQ-007 reqN_ready  out  1  requester N's operation is accepted this cycle.
REQ-008 reqN_op  in  OP_W  ALU opcode.
REQ-009 reqN_a / reqN_b  in  32 each  operands.
REQ-010 reqN_idim  in  1  IM-chaining flag.
REQ-011 rspN_valid  out  1  one-cycle result pulse to requester N.
REQ-012 rspN_r  out  32  result.
REQ-013 rspN_err  out  1  operation timed out.
REQ-014 alu_a / alu_b  out  32 each  to ALU operands.
REQ-015 alu_op  out  OP_W  to ALU opcode.
REQ-016 flag_idim  out  1  to ALU.
REQ-017 alu_r  in  32  ALU result.
REQ-018 alu_done  in  1  ALU completion.

Function
REQ-019 SHALL implement FSM IDLE -> RUN -> RESP -> RECOVER -> IDLE.
REQ-020 IDLE behaviour:
- alu_op SHALL equal `ALU_NOP.
- Operands SHALL be 0.
- The grant SHALL be computed combinationally from the valids.
- reqN_ready SHALL be high only for the granted requester.
- On valid&ready, op/a/b/idim and requester id SHALL be registered and the FSM SHALL enter RUN.
REQ-021 A requester SHALL hold valid and payload stable until ready; the arbiter SHALL NOT sample payload otherwise.
REQ-022 RUN behaviour:
- The registered op and operands SHALL be driven to the ALU unchanged every cycle.
- A cycle counter SHALL start at 1.
- When alu_done=1, alu_r SHALL be captured and the FSM SHALL go to RESP.
REQ-023 RUN SHALL accept alu_done in its first cycle, so a single-cycle op gives rspN_valid 2 cycles after the handshake cycle.
REQ-024 Timeout: if the counter reaches TIMEOUT_CYC with alu_done=0, the FSM SHALL go to RESP with err=1 and r=0. If alu_done=1 in that same cycle, done wins.
REQ-025 RESP SHALL pulse rspN_valid for exactly one cycle to the owning requester only, with rspN_r and rspN_err valid that cycle; outside RESP, rsp outputs SHALL be 0.
REQ-026 RECOVER SHALL last one cycle with alu_op=`ALU_NOP, so multicycle ALU counters return to idle before the next grant.
REQ-027 Throughput SHALL be at most one operation per 4 cycles (single-cycle ops); reqN_ready SHALL be 0 outside IDLE.
REQ-028 A requester deasserting valid before ready SHALL lose no state; grant is re-evaluated each IDLE cycle.

Reset
REQ-029 Reset SHALL asynchronously force:
- FSM to IDLE, counter to 0, captured result to 0.
- All rsp outputs to 0, ready outputs to 0.
- alu_op to `ALU_NOP, alu_a/alu_b/flag_idim to 0.
- RR pointer to favour requester 0.
REQ-030 Reset mid-RUN SHALL abandon the operation silently (no rsp pulse); the first post-reset cycle SHALL be IDLE with ALU NOP, which also restarts ALU internal counters.

Configuration
REQ-031 With macro ALU_ARB_RR_EN defined, arbitration SHALL be round-robin:
- On simultaneous valids, the requester not granted last SHALL win.
- The pointer SHALL update on each handshake.
REQ-032 Without ALU_ARB_RR_EN, requester 0 SHALL have fixed priority, and no pointer register SHALL exist.

Structure
REQ-033 Opcodes SHALL come from zpu_defines.sv.
REQ-034 Shared package zpu_alu_arb_pkg SHALL hold the FSM state enum, the requester-id typedef and the TIMEOUT_CYC counter width constant.
REQ-035 The 2-way grant logic SHALL be sub-module zpu_rr_arbiter, with the RR/fixed choice selected by ALU_ARB_RR_EN.

Verification
REQ-036 Single op: req0 ALU_PLUS, a=0x000000F0, b=0x0000003C, stub ALU adds with done=1 -> rsp0_valid 2 cycles after handshake, rsp0_r=0x0000012C, err=0, rsp1_valid=0.
REQ-037 Multicycle: stub ALU raises done 5 cycles into RUN with r=0xDEADBEEF -> operands/op stable all 5 cycles, rsp0_r=0xDEADBEEF, then one NOP cycle.
REQ-038 Contention: both valid continuously with RR enabled -> grants 0,1,0,1; with macro undefined -> grants 0,0,0 while req0 stays valid.
REQ-039 Timeout: TIMEOUT_CYC=8, done never asserted -> rsp1_valid with err=1, r=0, exactly 8 RUN cycles after handshake; then return to IDLE.
REQ-040 Reset asserted in 3rd RUN cycle -> outputs zero immediately, no rsp pulse, next request served normally.
